// File: rtl/host_resp_pkg.sv
// host_resp_pkg: shared types, status codes, header fields and byte-enable helper for host_slave_responder.
package host_resp_pkg;

    typedef enum logic [2:0] {IDLE, HDR, ADDR, WDATA, EXEC, RESP} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    localparam logic [7:0] STATUS_OK  = 8'h00;
    localparam logic [7:0] STATUS_ERR = 8'h01;

    localparam int HDR_WR     = 7;
    localparam int HDR_SZ_HI  = 6;
    localparam int HDR_SZ_LO  = 5;
    localparam int HDR_RSV_HI = 4;

    function automatic logic [3:0] be_from(input logic [1:0] size, input logic [1:0] a);
        return size == SZ_BYTE ? 4'b0001 << a : size == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

endpackage

// File: rtl/host_resp_mem.sv
// host_resp_mem: single-port 32-bit RAM with byte enables and registered read; contents are not reset.
module host_resp_mem #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          CLK,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge CLK) begin
        if (en && we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        if (en && !we) rdata <= mem[addr];
    end

endmodule

// File: rtl/host_slave_responder.sv
// host_slave_responder: executes host_slave request packets against a local word memory and returns responses.
// Define HOST_RESPONDER_STATS_EN to add the REQ_CNT/ERR_CNT request statistics ports.
module host_slave_responder
    import host_resp_pkg::*;
#(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter bit          WR_ACK    = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        RDEN,
    input  logic        RDEMPTY,
    input  logic [7:0]  RDDATA,
    output logic        WREN,
    input  logic        WRFULL,
    output logic [7:0]  WRDATA,
    output logic        BUSY
`ifdef HOST_RESPONDER_STATS_EN
    ,
    output logic [15:0] REQ_CNT,
    output logic [15:0] ERR_CNT
`endif
);

    localparam int          AW   = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN = 32'(MEM_WORDS * 4);

    state_t      state, state_n;
    logic        pend, err, err_n, is_wr, last, mem_en, fetch;
    logic [2:0]  cnt;
    logic [1:0]  size, lane;
    logic [7:0]  hdr;
    logic [31:0] addr, wdata, off, rdata;

    // pend marks a pop issued last cycle whose byte is on RDDATA now
    always_comb begin
        is_wr   = hdr[HDR_WR];
        size    = hdr[HDR_SZ_HI:HDR_SZ_LO];
        off     = addr - BASE_ADDR;
        err_n   = size == 2'd3 || hdr[HDR_RSV_HI:0] != '0 || (size == SZ_HALF && addr[0])
                  || (size == SZ_WORD && addr[1:0] != 2'b00) || off >= SPAN;
        fetch   = !RESET && !pend && !RDEMPTY && (state == IDLE || state == ADDR || state == WDATA);
        last    = cnt == (is_wr ? 3'd0 : 3'd4);
        lane    = 2'(cnt - 3'd1);
        mem_en  = state == EXEC && !err_n;
        RDEN    = fetch;
        WREN    = !RESET && state == RESP && !WRFULL;
        BUSY    = state != IDLE;
        WRDATA  = state != RESP ? 8'h00 : cnt == 3'd0 ? (err ? STATUS_ERR : STATUS_OK)
                  : err ? 8'h00 : rdata[8*lane +: 8];
        state_n = state;
        case (state)
            IDLE:    state_n = fetch ? HDR : IDLE;
            HDR:     state_n = pend ? ADDR : HDR;
            ADDR:    if (pend && cnt == 3'd3) state_n = is_wr ? WDATA : EXEC;
            WDATA:   if (pend && cnt == 3'd3) state_n = EXEC;
            EXEC:    state_n = (is_wr && !WR_ACK) ? IDLE : RESP;
            RESP:    if (WREN && last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            pend  <= 1'b0;
            cnt   <= 3'd0;
            hdr   <= 8'h00;
            addr  <= 32'h0;
            wdata <= 32'h0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            pend  <= fetch;
            if (pend && state == HDR) hdr <= RDDATA;
            if (pend && state == ADDR) addr <= {RDDATA, addr[31:8]};
            if (pend && state == WDATA) wdata <= {RDDATA, wdata[31:8]};
            if (state == EXEC) err <= err_n;
            if (pend && (state == ADDR || state == WDATA)) cnt <= cnt == 3'd3 ? 3'd0 : cnt + 3'd1;
            else if (WREN) cnt <= last ? 3'd0 : cnt + 3'd1;
        end
    end

    host_resp_mem #(.WORDS(MEM_WORDS)) u_mem (
        .CLK   (CLK),
        .en    (mem_en),
        .we    (is_wr),
        .be    (be_from(size, addr[1:0])),
        .addr  (off[AW+1:2]),
        .wdata (wdata),
        .rdata (rdata)
    );

`ifdef HOST_RESPONDER_STATS_EN
    logic done, done_err;

    // a request completes on its last pushed byte, or at EXEC for silent writes
    always_comb begin
        done     = (state == RESP && WREN && last) || (state == EXEC && is_wr && !WR_ACK);
        done_err = state == RESP ? err : err_n;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            REQ_CNT <= 16'h0;
            ERR_CNT <= 16'h0;
        end else begin
            REQ_CNT <= done && REQ_CNT != 16'hFFFF ? REQ_CNT + 16'd1 : REQ_CNT;
            ERR_CNT <= done && done_err && ERR_CNT != 16'hFFFF ? ERR_CNT + 16'd1 : ERR_CNT;
        end
    end
`endif

endmodule

// File: tb/tb_host_slave_responder.sv
// tb_host_slave_responder: table-driven scoreboard bench for host_slave_responder (WR_ACK=1 and WR_ACK=0 instances).
module tb_host_slave_responder;

    typedef struct packed {
        logic [7:0]  hdr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  st;
        logic [31:0] rd;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic       rden0, wren0, busy0, rdempty0 = 1'b1, wrfull0 = 1'b0;
    logic       rden1, wren1, busy1, rdempty1 = 1'b1;
    logic [7:0] rddata0 = 8'h00, wrdata0, rddata1 = 8'h00, wrdata1;
    logic [7:0] req0[$], req1[$], exp0[$], exp1[$];
    int         total = 0, passed = 0, npush0 = 0, npush1 = 0, n_req = 0, n_err = 0, n_req1 = 0;
    bit         tog = 1'b0, phase = 1'b0, full_hold = 1'b0;
    vec_t       vt[17];
`ifdef HOST_RESPONDER_STATS_EN
    logic [15:0] req_cnt0, err_cnt0, req_cnt1, err_cnt1;
`endif

    always #5 clk = ~clk;

    host_slave_responder #(.WR_ACK(1'b1)) dut0 (
        .CLK(clk), .RESET(rst), .RDEN(rden0), .RDEMPTY(rdempty0), .RDDATA(rddata0),
        .WREN(wren0), .WRFULL(wrfull0), .WRDATA(wrdata0), .BUSY(busy0)
`ifdef HOST_RESPONDER_STATS_EN
        , .REQ_CNT(req_cnt0), .ERR_CNT(err_cnt0)
`endif
    );

    host_slave_responder #(.WR_ACK(1'b0)) dut1 (
        .CLK(clk), .RESET(rst), .RDEN(rden1), .RDEMPTY(rdempty1), .RDDATA(rddata1),
        .WREN(wren1), .WRFULL(1'b0), .WRDATA(wrdata1), .BUSY(busy1)
`ifdef HOST_RESPONDER_STATS_EN
        , .REQ_CNT(req_cnt1), .ERR_CNT(err_cnt1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // FIFO flags move just after the clock edge so the DUT sees them stable for a whole cycle
    always @(posedge clk) begin
        #1;
        phase    = ~phase;
        rdempty0 = req0.size() == 0 || (tog && phase);
        wrfull0  = full_hold;
        rdempty1 = req1.size() == 0;
    end

    always @(negedge clk) begin
        if (rden0) begin
            check("pop_nonempty0", int'(req0.size() > 0), 1);
            if (req0.size() > 0) rddata0 = req0.pop_front();
        end
        if (wren0) begin
            npush0++;
            check("wren_while_full0", wrfull0, 0);
            check("resp_expected0", int'(exp0.size() > 0), 1);
            if (exp0.size() > 0) check("resp0", wrdata0, exp0.pop_front());
        end
        if (rden1) begin
            check("pop_nonempty1", int'(req1.size() > 0), 1);
            if (req1.size() > 0) rddata1 = req1.pop_front();
        end
        if (wren1) begin
            npush1++;
            check("resp_expected1", int'(exp1.size() > 0), 1);
            if (exp1.size() > 0) check("resp1", wrdata1, exp1.pop_front());
        end
    end

    // u=0 targets the acked instance, u=1 the silent-write instance
    task automatic send(input bit u, input vec_t v);
        for (int i = 0; i < 9; i++) begin
            logic [7:0] x;
            x = i == 0 ? v.hdr : i < 5 ? v.addr[8*(i-1) +: 8] : v.data[8*(i-5) +: 8];
            if (i < 5 || v.hdr[7]) begin
                if (u) req1.push_back(x);
                else req0.push_back(x);
            end
        end
        if (!u) begin
            exp0.push_back(v.st);
            if (!v.hdr[7]) for (int i = 0; i < 4; i++) exp0.push_back(v.rd[8*i +: 8]);
            n_req++;
            n_err += int'(v.st != 8'h00);
        end else begin
            if (!v.hdr[7]) begin
                exp1.push_back(v.st);
                for (int i = 0; i < 4; i++) exp1.push_back(v.rd[8*i +: 8]);
            end
            n_req1++;
        end
    endtask

    task automatic drain(input bit u, input string name);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (u ? (req1.size() == 0 && exp1.size() == 0 && !busy1)
                  : (req0.size() == 0 && exp0.size() == 0 && !busy0)) break;
        end
        check(name, int'(k < 300), 1);
    endtask

    task automatic stall(input vec_t v);
        int np;
        full_hold = 1'b1;
        send(0, v);
        for (int k = 0; k < 100 && req0.size() > 0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        np = npush0;
        repeat (20) @(negedge clk);
        check("stall_no_push", npush0, np);
        check("stall_busy", busy0, 1);
        check("stall_wrdata", wrdata0, v.st);
        full_hold = 1'b0;
        drain(0, "stall_drain");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vt[0]  = '{8'hC0, 32'h4000_0010, 32'hDEAD_BEEF, 8'h00, 32'h0};
        vt[1]  = '{8'h40, 32'h4000_0010, 32'h0,         8'h00, 32'hDEAD_BEEF};
        vt[2]  = '{8'h80, 32'h4000_0011, 32'h5555_5555, 8'h00, 32'h0};
        vt[3]  = '{8'h40, 32'h4000_0010, 32'h0,         8'h00, 32'hDEAD_55EF};
        vt[4]  = '{8'hA0, 32'h4000_0012, 32'h1234_5678, 8'h00, 32'h0};
        vt[5]  = '{8'h40, 32'h4000_0010, 32'h0,         8'h00, 32'h1234_55EF};
        vt[6]  = '{8'hC0, 32'h4000_0000, 32'h0BAD_F00D, 8'h00, 32'h0};
        vt[7]  = '{8'h20, 32'h4000_0001, 32'h0,         8'h01, 32'h0};
        vt[8]  = '{8'h40, 32'h3FFF_FFFC, 32'h0,         8'h01, 32'h0};
        vt[9]  = '{8'hC0, 32'h4000_0400, 32'hFFFF_FFFF, 8'h01, 32'h0};
        vt[10] = '{8'h40, 32'h4000_0000, 32'h0,         8'h00, 32'h0BAD_F00D};
        vt[11] = '{8'hC0, 32'h4000_03FC, 32'h1122_3344, 8'h00, 32'h0};
        vt[12] = '{8'h00, 32'h4000_03FF, 32'h0,         8'h00, 32'h1122_3344};
        vt[13] = '{8'h60, 32'h4000_0010, 32'h0,         8'h01, 32'h0};
        vt[14] = '{8'h41, 32'h4000_0010, 32'h0,         8'h01, 32'h0};
        vt[15] = '{8'hC0, 32'h4000_0012, 32'hAAAA_AAAA, 8'h01, 32'h0};
        vt[16] = '{8'h20, 32'h4000_0012, 32'h0,         8'h00, 32'h1234_55EF};

        repeat (2) @(negedge clk);
        check("reset_outputs0", {rden0, wren0, busy0, wrdata0}, 0);
        check("reset_outputs1", {rden1, wren1, busy1, wrdata1}, 0);
`ifdef HOST_RESPONDER_STATS_EN
        check("reset_counters", {req_cnt0, err_cnt0}, 0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (vt[i]) begin
            send(0, vt[i]);
            drain(0, "vector_drain");
        end

        tog = 1'b1;
        v = '{8'h40, 32'h4000_0010, 32'h0, 8'h00, 32'h1234_55EF};
        send(0, v);
        drain(0, "toggle_empty_drain");
        tog = 1'b0;

        stall(v);
        v = '{8'h20, 32'h4000_0001, 32'h0, 8'h01, 32'h0};
        stall(v);
`ifdef HOST_RESPONDER_STATS_EN
        check("req_cnt", req_cnt0, n_req);
        check("err_cnt", err_cnt0, n_err);
`endif

        req0.push_back(8'h40);
        req0.push_back(8'h10);
        req0.push_back(8'h00);
        req0.push_back(8'h00);
        for (int k = 0; k < 50 && req0.size() > 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("mid_packet_busy", busy0, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs", {rden0, wren0, busy0, wrdata0}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        n_req = 0;
        n_err = 0;
        n_req1 = 0;
        v = '{8'h40, 32'h4000_0000, 32'h0, 8'h00, 32'h0BAD_F00D};
        send(0, v);
        drain(0, "post_reset_drain");
`ifdef HOST_RESPONDER_STATS_EN
        check("post_reset_req_cnt", req_cnt0, n_req);
`endif

        v = '{8'hC0, 32'h4000_0020, 32'hA5A5_A5A5, 8'h00, 32'h0};
        send(1, v);
        v = '{8'hA0, 32'h4000_0020, 32'h0000_BEEF, 8'h00, 32'h0};
        send(1, v);
        v = '{8'h80, 32'h4000_0023, 32'h7700_0000, 8'h00, 32'h0};
        send(1, v);
        drain(1, "noack_drain");
        check("noack_pushes", npush1, 0);
`ifdef HOST_RESPONDER_STATS_EN
        check("noack_req_cnt", req_cnt1, n_req1);
`endif
        v = '{8'h40, 32'h4000_0020, 32'h0, 8'h00, 32'h77A5_BEEF};
        send(1, v);
        drain(1, "noack_read_drain");
        check("noack_read_pushes", npush1, 5);

        check("scoreboard_empty", exp0.size() + exp1.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
